// File: rtl/rram_ctrl_pkg.sv
// Shared types and constants for the RRAM array controller.
package rram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_SET   = 2'd1,
        OP_RESET = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ADDR   = 3'd1;
    localparam logic [2:0] REG_TIME   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RDATA  = 3'd4;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_SET   = 2'b10;
    localparam logic [1:0] MODE_RESET = 2'b11;

    localparam int TIME_SETUP_RST = 1;
    localparam int TIME_PULSE_RST = 1;

    function automatic logic [1:0] op_mode(input logic [1:0] op);
        logic [1:0] m;
        case (op)
            OP_READ:  m = MODE_READ;
            OP_SET:   m = MODE_SET;
            OP_RESET: m = MODE_RESET;
            default:  m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rram_pulse_timer.sv
// Loadable down-counter timing the SETUP and PULSE phases; 'last' flags the
// final cycle of a phase (count == 1).
module rram_pulse_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    output logic          last,
    output logic          zero
);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - TW'(1);
        end
    end

    assign last = (count_reg == TW'(1));
    assign zero = (count_reg == '0);

endmodule

// File: rtl/rram_array_ctrl.sv
// Wishbone-mapped sequencer for READ/SET/RESET pulses on a 1T1R RRAM array:
// register file, bus decode and the IDLE->SETUP->PULSE->HOLD state machine.
module rram_array_ctrl
    import rram_ctrl_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int TW   = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [ROWS-1:0] WL,
    output logic [COLS-1:0] BL,
    input  logic [COLS-1:0] SL,
    output logic [1:0]      mode_o,
    output logic            busy_o,
    output logic            irq_o
);

    state_e          state_reg;
    logic [1:0]      op_reg;
    logic            irq_en_reg;
    logic [7:0]      row_reg;
    logic [7:0]      col_reg;
    logic [TW-1:0]   pulse_reg;
    logic [TW-1:0]   setup_reg;
    logic            done_reg;
    logic            err_reg;
    logic [COLS-1:0] rdata_reg;
    logic [ROWS-1:0] wl_reg;
    logic [COLS-1:0] bl_reg;
    logic [1:0]      mode_reg;
    logic            ack_reg;
    logic [31:0]     dat_reg;

    logic            busy;
    logic            wb_req;
    logic            wb_wr;
    logic [2:0]      offset;
    logic            in_cfg;
    logic            cfg_wr;
    logic            drop_err;
    logic            start_req;
    logic            start_ok;
    logic            start_bad;
    logic            addr_ok;
    logic            clr_done;
    logic            clr_err;
    logic [1:0]      op_next;
    logic            irq_en_next;
    logic [7:0]      row_next;
    logic [7:0]      col_next;
    logic [TW-1:0]   pulse_next;
    logic [TW-1:0]   setup_next;
    logic [TW-1:0]   setup_ld;
    logic [TW-1:0]   pulse_ld;
    logic            timer_load;
    logic [TW-1:0]   timer_value;
    logic            timer_last;
    logic            timer_zero;
    logic [31:0]     rd_data;
    logic [ROWS-1:0] wl_onehot;
    logic [COLS-1:0] bl_onehot;

    assign busy   = (state_reg != ST_IDLE);
    assign wb_req = wbs_cyc_i & wbs_stb_i & ~ack_reg;
    assign wb_wr  = wb_req & wbs_we_i;
    assign offset = wbs_adr_i[4:2];
    assign in_cfg = (offset == REG_CTRL) | (offset == REG_ADDR) | (offset == REG_TIME);

    assign cfg_wr   = wb_wr & ~busy & in_cfg;
    assign drop_err = wb_wr & busy & in_cfg;

    assign op_next     = wbs_sel_i[0] ? wbs_dat_i[1:0]  : op_reg;
    assign irq_en_next = wbs_sel_i[0] ? wbs_dat_i[3]    : irq_en_reg;
    assign row_next    = wbs_sel_i[0] ? wbs_dat_i[7:0]  : row_reg;
    assign col_next    = wbs_sel_i[1] ? wbs_dat_i[15:8] : col_reg;

    genvar gi;
    generate
        for (gi = 0; gi < TW; gi++) begin : g_time_lanes
            assign pulse_next[gi] = wbs_sel_i[gi/8]     ? wbs_dat_i[gi]      : pulse_reg[gi];
            assign setup_next[gi] = wbs_sel_i[2 + gi/8] ? wbs_dat_i[16 + gi] : setup_reg[gi];
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_wl_dec
            assign wl_onehot[gi] = (row_reg == 8'(gi));
        end
        for (gi = 0; gi < COLS; gi++) begin : g_bl_dec
            assign bl_onehot[gi] = (col_reg == 8'(gi));
        end
    endgenerate

    // Start validates the op being written now against the already-held address.
    assign start_req = wb_wr & ~busy & (offset == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[2];
    assign addr_ok   = ({1'b0, row_reg} < 9'(ROWS)) && ({1'b0, col_reg} < 9'(COLS));
    assign start_ok  = start_req & (op_next != OP_RSVD) & addr_ok;
    assign start_bad = start_req & ~start_ok;

    assign clr_done = wb_wr & (offset == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[1];
    assign clr_err  = wb_wr & (offset == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];

    assign setup_ld    = (setup_reg == '0) ? TW'(1) : setup_reg;
    assign pulse_ld    = (pulse_reg == '0) ? TW'(1) : pulse_reg;
    assign timer_load  = start_ok | ((state_reg == ST_SETUP) & timer_last);
    assign timer_value = (state_reg == ST_IDLE) ? setup_ld : pulse_ld;

    rram_pulse_timer #(.TW(TW)) u_timer (
        .clk        (wb_clk_i),
        .reset      (wb_rst_i),
        .load       (timer_load),
        .load_value (timer_value),
        .last       (timer_last),
        .zero       (timer_zero)
    );

    always_comb begin
        rd_data = '0;
        case (offset)
            REG_CTRL:   rd_data = {28'b0, irq_en_reg, 1'b0, op_reg};
            REG_ADDR:   rd_data = {16'b0, col_reg, row_reg};
            REG_TIME: begin
                rd_data[TW-1:0]       = pulse_reg;
                rd_data[16+TW-1:16]   = setup_reg;
            end
            REG_STATUS: rd_data = {29'b0, err_reg, done_reg, busy};
            REG_RDATA:  rd_data[COLS-1:0] = rdata_reg;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= wb_req;
            if (wb_req) begin
                dat_reg <= wbs_we_i ? 32'b0 : rd_data;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_reg     <= '0;
            irq_en_reg <= 1'b0;
            row_reg    <= '0;
            col_reg    <= '0;
            pulse_reg  <= TW'(TIME_PULSE_RST);
            setup_reg  <= TW'(TIME_SETUP_RST);
        end else if (cfg_wr) begin
            case (offset)
                REG_CTRL: begin
                    op_reg     <= op_next;
                    irq_en_reg <= irq_en_next;
                end
                REG_ADDR: begin
                    row_reg <= row_next;
                    col_reg <= col_next;
                end
                REG_TIME: begin
                    pulse_reg <= pulse_next;
                    setup_reg <= setup_next;
                end
                default: ;
            endcase
        end
    end

    // Status set events are written after the W1C clears so that a set wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            wl_reg    <= '0;
            bl_reg    <= '0;
            mode_reg  <= MODE_IDLE;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (clr_done) done_reg <= 1'b0;
            if (clr_err) err_reg <= 1'b0;
            if (drop_err | start_bad) err_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg <= ST_SETUP;
                        mode_reg  <= op_mode(op_next);
                        bl_reg    <= (op_next == OP_READ) ? {COLS{1'b1}} : bl_onehot;
                        done_reg  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (timer_last) begin
                        state_reg <= ST_PULSE;
                        wl_reg    <= wl_onehot;
                    end
                end
                ST_PULSE: begin
                    if (timer_last) begin
                        state_reg <= ST_HOLD;
                        wl_reg    <= '0;
                        if (op_reg == OP_READ) rdata_reg <= SL;
                    end
                end
                ST_HOLD: begin
                    state_reg <= ST_IDLE;
                    bl_reg    <= '0;
                    mode_reg  <= MODE_IDLE;
                    done_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign WL        = wl_reg;
    assign BL        = bl_reg;
    assign mode_o    = mode_reg;
    assign busy_o    = busy;
    assign irq_o     = done_reg & irq_en_reg;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i, timer_zero};

endmodule

// File: tb/tb_rram_array_ctrl.sv
// Randomized self-checking bench for rram_array_ctrl against a phase-timeline
// reference model of the register map and operation sequencing.
module tb_rram_array_ctrl;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int TW   = 16;

    localparam logic [2:0] O_CTRL   = 3'd0;
    localparam logic [2:0] O_ADDR   = 3'd1;
    localparam logic [2:0] O_TIME   = 3'd2;
    localparam logic [2:0] O_STATUS = 3'd3;
    localparam logic [2:0] O_RDATA  = 3'd4;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            wbs_cyc_i = 1'b0;
    logic            wbs_stb_i = 1'b0;
    logic            wbs_we_i = 1'b0;
    logic [3:0]      wbs_sel_i = 4'h0;
    logic [31:0]     wbs_adr_i = '0;
    logic [31:0]     wbs_dat_i = '0;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic [ROWS-1:0] WL;
    logic [COLS-1:0] BL;
    logic [COLS-1:0] SL = '0;
    logic [1:0]      mode_o;
    logic            busy_o;
    logic            irq_o;

    int n_checks = 0;
    int n_errors = 0;

    rram_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .TW(TW)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .WL        (WL),
        .BL        (BL),
        .SL        (SL),
        .mode_o    (mode_o),
        .busy_o    (busy_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [2:0] off, input logic [31:0] data,
                             input logic [3:0] sel, output logic [31:0] rdata);
        bit got = 0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = {27'b0, off, 2'b00};
        wbs_dat_i = data;
        wbs_sel_i = sel;
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                got = 1;
                rdata = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) check_eq("wb_ack_timeout", {31'b0, wbs_ack_o}, 32'd1);
    endtask

    task automatic wb_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(1'b1, off, data, sel, dummy);
    endtask

    task automatic wb_check(input string tag, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] d;
        wb_access(1'b0, off, 32'h0, 4'hF, d);
        check_eq(tag, d, exp);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) break;
            @(posedge wb_clk_i);
            #1;
        end
        check_eq("idle_timeout", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic check_array_idle(input string tag);
        check_eq({tag, "_wl"},   32'(WL), 32'h0);
        check_eq({tag, "_bl"},   32'(BL), 32'h0);
        check_eq({tag, "_mode"}, 32'(mode_o), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'h0);
    endtask

    logic [31:0] m_rdata = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_array_idle("rst");
        check_eq("rst_irq", 32'(irq_o), 32'h0);
        check_eq("rst_ack", 32'(wbs_ack_o), 32'h0);
        check_eq("rst_dat", wbs_dat_o, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        wb_check("rst_ctrl",   O_CTRL,   32'h0);
        wb_check("rst_addr",   O_ADDR,   32'h0);
        wb_check("rst_time",   O_TIME,   32'h0001_0001);
        wb_check("rst_status", O_STATUS, 32'h0);
        wb_check("rst_rdata",  O_RDATA,  32'h0);
        wb_check("rst_off5",   3'd5,     32'h0);

        // Byte lanes
        wb_write(O_TIME, 32'hFFFF_FF07, 4'b0001);
        wb_check("lane_lo", O_TIME, 32'h0001_0007);
        wb_write(O_TIME, 32'h0003_00FF, 4'b1100);
        wb_check("lane_hi", O_TIME, 32'h0003_0007);

        // Config writes while busy are dropped and flag err
        wb_write(O_TIME, 32'h000A_000A, 4'hF);
        wb_write(O_ADDR, {16'h0, 8'd5, 8'd3}, 4'hF);
        wb_write(O_CTRL, 32'h5, 4'hF);
        check_eq("bz_busy", 32'(busy_o), 32'h1);
        wb_write(O_TIME, 32'h0002_0002, 4'hF);
        wb_write(O_CTRL, 32'h8, 4'hF);
        wb_check("bz_status", O_STATUS, 32'h5);
        wb_check("bz_time",   O_TIME,   32'h000A_000A);
        wb_check("bz_ctrl",   O_CTRL,   32'h1);
        wait_idle(60);
        wb_check("bz_done", O_STATUS, 32'h6);
        check_eq("bz_irq_off", 32'(irq_o), 32'h0);
        wb_write(O_STATUS, 32'h4, 4'hF);
        wb_check("w1c_err", O_STATUS, 32'h2);
        wb_write(O_STATUS, 32'h2, 4'hF);
        wb_check("w1c_done", O_STATUS, 32'h0);

        // Randomized operations against a phase-timeline model
        for (int t = 0; t < 20; t++) begin
            int op, row, col, s, p, ie, S, P;
            bit valid;
            op  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            row = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
            col = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
            s   = $urandom_range(0, 4);
            p   = $urandom_range(0, 4);
            ie  = $urandom_range(0, 1);
            S   = (s == 0) ? 1 : s;
            P   = (p == 0) ? 1 : p;
            valid = (op != 3) && (row < ROWS) && (col < COLS);
            $display("txn %0d op=%0d row=%0d col=%0d setup=%0d pulse=%0d irq_en=%0d valid=%0d",
                     t, op, row, col, s, p, ie, valid);

            wb_write(O_TIME, (32'(s) << 16) | 32'(p), 4'hF);
            wb_write(O_ADDR, (32'(col) << 8) | 32'(row), 4'hF);
            wb_write(O_STATUS, 32'h6, 4'hF);
            wb_write(O_CTRL, (32'(ie) << 3) | 32'h4 | 32'(op), 4'hF);

            if (valid) begin
                for (int k = 0; k <= S + P; k++) begin
                    logic [31:0] exp_bl, exp_wl;
                    exp_bl = (op == 0) ? 32'hFFFF : (32'd1 << col);
                    exp_wl = (k >= S && k < S + P) ? (32'd1 << row) : 32'd0;
                    check_eq($sformatf("t%0d_busy_c%0d", t, k), 32'(busy_o), 32'h1);
                    check_eq($sformatf("t%0d_wl_c%0d", t, k), 32'(WL), exp_wl);
                    check_eq($sformatf("t%0d_bl_c%0d", t, k), 32'(BL), exp_bl);
                    check_eq($sformatf("t%0d_mode_c%0d", t, k), 32'(mode_o), 32'(op + 1));
                    check_eq($sformatf("t%0d_irq_c%0d", t, k), 32'(irq_o), 32'h0);
                    SL = COLS'($urandom);
                    if (k == S + P - 1 && op == 0) m_rdata = 32'(SL);
                    @(posedge wb_clk_i);
                    #1;
                end
                check_array_idle($sformatf("t%0d_end", t));
                check_eq($sformatf("t%0d_irq", t), 32'(irq_o), 32'(ie));
                SL = COLS'($urandom);
                wb_check($sformatf("t%0d_status", t), O_STATUS, 32'h2);
                wb_check($sformatf("t%0d_rdata", t), O_RDATA, m_rdata);
                wb_check($sformatf("t%0d_ctrl", t), O_CTRL, (32'(ie) << 3) | 32'(op));
            end else begin
                for (int k = 0; k < 3; k++) begin
                    check_eq($sformatf("t%0d_nobusy_c%0d", t, k), 32'(busy_o), 32'h0);
                    @(posedge wb_clk_i);
                    #1;
                end
                wb_check($sformatf("t%0d_err", t), O_STATUS, 32'h4);
                wb_check($sformatf("t%0d_rdata_keep", t), O_RDATA, m_rdata);
            end
        end

        // Asynchronous reset during PULSE
        wb_write(O_TIME, 32'h0001_0008, 4'hF);
        wb_write(O_ADDR, {16'h0, 8'd2, 8'd4}, 4'hF);
        wb_write(O_CTRL, 32'h5, 4'hF);
        @(posedge wb_clk_i);
        #1;
        check_eq("ar_wl_pulse", 32'(WL), 32'h0010);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        #1;
        check_array_idle("ar");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wb_check("ar_status", O_STATUS, 32'h0);
        wb_check("ar_time",   O_TIME,   32'h0001_0001);
        wb_check("ar_addr",   O_ADDR,   32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
